// File: rtl/ahb_periph_bridge_pkg.sv
// Shared state encoding, AHB transfer codes and slot-decode helpers for the
// AHB-to-peripheral bridges.
package ahb_periph_bridge_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WR,
      ST_RD1,
      ST_RD2,
      ST_ERR1,
      ST_ERR2
   } bridge_state_e;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic [2:0] HSIZE_WORD = 3'b010;
   localparam logic [1:0] WORD_ALIGN = 2'b00;

   function automatic logic is_active(input logic [1:0] htrans);
      return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
   endfunction

   function automatic logic [31:0] slot_index(input logic [31:0] addr,
                                              input int unsigned slot_bits,
                                              input int unsigned idx_bits);
      return (addr >> slot_bits) & ((32'd1 << idx_bits) - 32'd1);
   endfunction

endpackage

// File: rtl/ahb_slot_decode.sv
// Slot index to one-hot peripheral select, plus an in-range flag.
module ahb_slot_decode
   import ahb_periph_bridge_pkg::*;
#(
   parameter int unsigned NUM_SLAVES = 4,
   parameter int unsigned IDX_BITS   = 4
) (
   input  logic [IDX_BITS-1:0]   idx_i,
   output logic [NUM_SLAVES-1:0] onehot_o,
   output logic                  legal_o
);

   always_comb begin
      onehot_o = '0;
      for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
         if (32'(idx_i) == i) onehot_o[i] = 1'b1;
      end
   end

   assign legal_o = (32'(idx_i) < NUM_SLAVES);

endmodule

// File: rtl/ahb_periph_bridge.sv
// AHB-Lite responder driving the peripheral sel/read/write strobe interface.
// Optional macro AHB_BRIDGE_ERR_EN: illegal accesses get a two-cycle ERROR.
module ahb_periph_bridge
   import ahb_periph_bridge_pkg::*;
#(
   parameter int unsigned NUM_SLAVES = 4,
   parameter int unsigned SLOT_BITS  = 12,
   parameter int unsigned IDX_BITS   = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  HSEL,
   input  logic [31:0]           HADDR,
   input  logic [1:0]            HTRANS,
   input  logic                  HWRITE,
   input  logic [2:0]            HSIZE,
   input  logic [31:0]           HWDATA,
   input  logic                  HREADY,
   output logic [31:0]           HRDATA,
   output logic                  HREADYOUT,
   output logic                  HRESP,
   output logic [NUM_SLAVES-1:0] psel,
   output logic                  pread,
   output logic                  pwrite,
   output logic [31:0]           pwdata,
   output logic [SLOT_BITS-1:0]  paddr,
   input  logic [31:0]           prdata
);

   bridge_state_e state_q, state_d, accept_state;
   logic [NUM_SLAVES-1:0] sel_q, sel_d, dec_onehot;
   logic [SLOT_BITS-1:0]  off_q, off_d;
   logic [31:0]           hrdata_q, hrdata_d;
   logic [IDX_BITS-1:0]   dec_idx;
   logic                  dec_legal, accept, acc_legal, addr_phase;

   assign dec_idx = IDX_BITS'(slot_index(HADDR, SLOT_BITS, IDX_BITS));

   ahb_slot_decode #(
      .NUM_SLAVES (NUM_SLAVES),
      .IDX_BITS   (IDX_BITS)
   ) u_decode (
      .idx_i    (dec_idx),
      .onehot_o (dec_onehot),
      .legal_o  (dec_legal)
   );

   assign accept     = HSEL & is_active(HTRANS) & HREADY;
   assign acc_legal  = dec_legal & (HADDR[1:0] == WORD_ALIGN) & (HSIZE == HSIZE_WORD);
   assign addr_phase = (state_q != ST_RD1) && (state_q != ST_ERR1);

   always_comb begin
      accept_state = ST_IDLE;
      if (accept) begin
         if (acc_legal) accept_state = HWRITE ? ST_WR : ST_RD1;
`ifdef AHB_BRIDGE_ERR_EN
         else           accept_state = ST_ERR1;
`endif
      end

      case (state_q)
         ST_RD1:  state_d = ST_RD2;
         ST_ERR1: state_d = ST_ERR2;
         default: state_d = accept_state;
      endcase

      sel_d = sel_q;
      off_d = off_q;
      if (addr_phase && accept) begin
         sel_d = dec_onehot;
         off_d = HADDR[SLOT_BITS-1:0];
      end
      hrdata_d = (state_q == ST_RD1) ? prdata : hrdata_q;
   end

   always_comb begin
      psel      = '0;
      pread     = 1'b0;
      pwrite    = 1'b0;
      pwdata    = '0;
      paddr     = '0;
      HREADYOUT = 1'b1;
      HRESP     = 1'b0;
      case (state_q)
         ST_WR: begin
            psel   = sel_q;
            pwrite = 1'b1;
            pwdata = HWDATA;
            paddr  = off_q;
         end
         ST_RD1: begin
            psel      = sel_q;
            pread     = 1'b1;
            paddr     = off_q;
            HREADYOUT = 1'b0;
         end
`ifdef AHB_BRIDGE_ERR_EN
         ST_ERR1: begin
            HRESP     = 1'b1;
            HREADYOUT = 1'b0;
         end
         ST_ERR2: HRESP = 1'b1;
`endif
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         sel_q    <= '0;
         off_q    <= '0;
         hrdata_q <= '0;
      end else begin
         state_q  <= state_d;
         sel_q    <= sel_d;
         off_q    <= off_d;
         hrdata_q <= hrdata_d;
      end
   end

`ifdef AHB_BRIDGE_ERR_EN
   assign HRDATA = hrdata_q;
`else
   // Illegal reads complete in one cycle; mask the held capture to zero there.
   logic ill_rd_q, ill_rd_d;
   assign ill_rd_d = addr_phase & accept & ~acc_legal & ~HWRITE;

   always_ff @(posedge clk) begin
      if (reset) ill_rd_q <= 1'b0;
      else       ill_rd_q <= ill_rd_d;
   end

   assign HRDATA = ill_rd_q ? '0 : hrdata_q;
`endif

endmodule

// File: tb/tb_ahb_periph_bridge.sv
// Randomised self-checking bench for ahb_periph_bridge against a
// transaction-level model of the AHB data phases.
module tb_ahb_periph_bridge;
   import ahb_periph_bridge_pkg::*;

   localparam int unsigned NS = 4;
   localparam int unsigned SB = 12;
   localparam int unsigned IB = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          HSEL, HWRITE, HREADY;
   logic [31:0]   HADDR, HWDATA, HRDATA, pwdata, prdata;
   logic [1:0]    HTRANS;
   logic [2:0]    HSIZE;
   logic          HREADYOUT, HRESP, pread, pwrite;
   logic [NS-1:0] psel;
   logic [SB-1:0] paddr;

   always #5 clk = ~clk;

   ahb_periph_bridge #(
      .NUM_SLAVES (NS),
      .SLOT_BITS  (SB),
      .IDX_BITS   (IB)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .HSEL      (HSEL),
      .HADDR     (HADDR),
      .HTRANS    (HTRANS),
      .HWRITE    (HWRITE),
      .HSIZE     (HSIZE),
      .HWDATA    (HWDATA),
      .HREADY    (HREADY),
      .HRDATA    (HRDATA),
      .HREADYOUT (HREADYOUT),
      .HRESP     (HRESP),
      .psel      (psel),
      .pread     (pread),
      .pwrite    (pwrite),
      .pwdata    (pwdata),
      .paddr     (paddr),
      .prdata    (prdata)
   );

   // Peripherals: four registers per slot, aliased across the slot.
   logic [31:0] pmem [NS][4];

   always_comb begin
      prdata = '0;
      for (int i = 0; i < NS; i++)
         if (psel[i] && pread) prdata |= pmem[i][paddr[3:2]];
   end

   always @(posedge clk) begin
      if (!reset)
         for (int i = 0; i < NS; i++)
            if (psel[i] && pwrite) pmem[i][paddr[3:2]] <= pwdata;
   end

   // Reference model: one record per expected data-phase cycle.
   typedef struct {
      logic [NS-1:0] psel;
      logic          pread, pwrite, ready, resp;
      logic [31:0]   pwdata, wdata, rdata;
      logic [SB-1:0] paddr;
      int            hr_mode;   // 0 hold last capture, 1 new capture, 2 zero
   } rec_t;

   rec_t        q[$];
   logic [31:0] refmem [NS][4];
   logic [31:0] last_rd;
   int          n_chk = 0;
   int          n_pass = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s @%0t: got 0x%08h expected 0x%08h", tag, $time, act, exp);
   endtask

   function automatic rec_t idle_rec();
      rec_t r;
      r.psel = '0; r.pread = 1'b0; r.pwrite = 1'b0; r.ready = 1'b1; r.resp = 1'b0;
      r.pwdata = '0; r.wdata = $urandom(); r.rdata = '0; r.paddr = '0; r.hr_mode = 0;
      return r;
   endfunction

   task automatic push_transfer(input logic [31:0] addr, input logic wr,
                                input logic [2:0] size, input logic [31:0] wd);
      rec_t        r;
      logic [3:0]  idx;
      logic [11:0] off;
      logic        legal;
      idx   = addr[SB+IB-1:SB];
      off   = addr[SB-1:0];
      legal = (int'(idx) < NS) && (addr[1:0] == 2'b00) && (size == HSIZE_WORD);
      r = idle_rec();
      if (legal && wr) begin
         r.psel = NS'(1 << idx); r.pwrite = 1'b1; r.pwdata = wd; r.wdata = wd; r.paddr = off;
         refmem[idx[1:0]][off[3:2]] = wd;
         q.push_back(r);
      end else if (legal) begin
         r.psel = NS'(1 << idx); r.pread = 1'b1; r.paddr = off; r.ready = 1'b0;
         q.push_back(r);
         r = idle_rec();
         r.hr_mode = 1; r.rdata = refmem[idx[1:0]][off[3:2]];
         q.push_back(r);
      end else begin
`ifdef AHB_BRIDGE_ERR_EN
         r.resp = 1'b1; r.ready = 1'b0;
         q.push_back(r);
         r = idle_rec();
         r.resp = 1'b1;
         q.push_back(r);
`else
         r.wdata = wd;
         if (!wr) r.hr_mode = 2;
         q.push_back(r);
`endif
      end
   endtask

   // One bus cycle: drive data phase of the expected record plus a new address phase.
   task automatic cycle(input logic sel, input logic [1:0] trans, input logic [31:0] addr,
                        input logic wr, input logic [2:0] size, input logic [31:0] wd);
      rec_t        cur;
      logic [31:0] exp_hr;
      if (q.size() > 0) cur = q.pop_front();
      else              cur = idle_rec();
      HWDATA = cur.wdata; HREADY = cur.ready;
      HSEL = sel; HTRANS = trans; HADDR = addr; HWRITE = wr; HSIZE = size;
      @(negedge clk);
      exp_hr = (cur.hr_mode == 1) ? cur.rdata : (cur.hr_mode == 2) ? 32'h0 : last_rd;
      chk("psel",      32'(psel),      32'(cur.psel));
      chk("pread",     32'(pread),     32'(cur.pread));
      chk("pwrite",    32'(pwrite),    32'(cur.pwrite));
      chk("pwdata",    pwdata,         cur.pwdata);
      chk("paddr",     32'(paddr),     32'(cur.paddr));
      chk("HREADYOUT", 32'(HREADYOUT), 32'(cur.ready));
      chk("HRESP",     32'(HRESP),     32'(cur.resp));
      chk("HRDATA",    HRDATA,         exp_hr);
      if (cur.hr_mode == 1) last_rd = cur.rdata;
      @(posedge clk);
      if (reset) begin
         q.delete();
         last_rd = '0;
      end else if (sel && (trans == HTRANS_NONSEQ || trans == HTRANS_SEQ) && cur.ready) begin
         push_transfer(addr, wr, size, wd);
      end
      #1;
   endtask

   task automatic idle();
      cycle(1'b1, HTRANS_IDLE, 32'h0, 1'b0, HSIZE_WORD, 32'h0);
   endtask

   task automatic wr(input logic [3:0] slot, input logic [11:0] off, input logic [31:0] d);
      cycle(1'b1, HTRANS_NONSEQ, {16'h4000, slot, off}, 1'b1, HSIZE_WORD, d);
   endtask

   task automatic rd(input logic [3:0] slot, input logic [11:0] off);
      cycle(1'b1, HTRANS_NONSEQ, {16'h4000, slot, off}, 1'b0, HSIZE_WORD, 32'h0);
      idle();
   endtask

   task automatic acc(input logic [31:0] addr, input logic w, input logic [2:0] size);
      cycle(1'b1, HTRANS_NONSEQ, addr, w, size, 32'hDEAD_BEEF);
      idle();
   endtask

   initial begin
      logic        s, w;
      logic [1:0]  t;
      logic [2:0]  z;
      logic [11:0] off;
      int          pick, slot;

      reset = 1'b1; last_rd = '0;
      HSEL = 1'b0; HTRANS = HTRANS_IDLE; HADDR = '0; HWRITE = 1'b0;
      HSIZE = HSIZE_WORD; HWDATA = '0; HREADY = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_psel",   32'(psel),      32'h0);
      chk("rst_pread",  32'(pread),     32'h0);
      chk("rst_pwrite", 32'(pwrite),    32'h0);
      chk("rst_pwdata", pwdata,         32'h0);
      chk("rst_paddr",  32'(paddr),     32'h0);
      chk("rst_ready",  32'(HREADYOUT), 32'h1);
      chk("rst_resp",   32'(HRESP),     32'h0);
      chk("rst_hrdata", HRDATA,         32'h0);
      @(posedge clk); #1;
      reset = 1'b0;

      for (int sl = 0; sl < NS; sl++)
         for (int wi = 0; wi < 4; wi++)
            wr(4'(sl), 12'(wi * 4), $urandom());

      wr(4'd1, 12'h000, 32'h0000_A5A5);
      wr(4'd1, 12'h004, 32'h0000_003C);
      idle();
      rd(4'd1, 12'h004);
      idle();

      wr(4'd0, 12'h008, 32'h1234_5678);
      rd(4'd2, 12'h00C);
      wr(4'd3, 12'h100, 32'hCAFE_F00D);
      idle();

      acc({16'h4000, 4'd5, 12'h000}, 1'b0, HSIZE_WORD);
      acc({16'h4000, 4'd2, 12'h000}, 1'b0, 3'b000);
      acc({16'h4000, 4'd1, 12'h002}, 1'b1, HSIZE_WORD);
      acc({16'h4000, 4'd3, 12'h006}, 1'b0, HSIZE_WORD);

      cycle(1'b1, HTRANS_NONSEQ, {16'h4000, 4'd2, 12'h008}, 1'b0, HSIZE_WORD, 32'h0);
      reset = 1'b1;
      idle();
      reset = 1'b0;
      repeat (3) idle();

      repeat (400) begin
         s    = ($urandom_range(0, 9) != 0);
         pick = $urandom_range(0, 7);
         t    = (pick == 0) ? HTRANS_IDLE : (pick == 1) ? HTRANS_BUSY :
                (pick < 5)  ? HTRANS_NONSEQ : HTRANS_SEQ;
         slot = $urandom_range(0, 5);
         off  = 12'($urandom_range(0, 4095)) & 12'hFFC;
         if ($urandom_range(0, 7) == 0) off[1:0] = 2'($urandom_range(1, 3));
         z    = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 1)) : HSIZE_WORD;
         w    = 1'($urandom_range(0, 1));
         cycle(s, t, {16'($urandom()), 4'(slot), off}, w, z, $urandom());
      end
      repeat (3) idle();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
